// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and default latency shared by the mul/div sequencer.
package mdu_pkg;
   localparam int LAT_DEF = 5;
   localparam logic [3:0] OP_NONE  = 4'b0000;
   localparam logic [3:0] OP_MULT  = 4'b0101;
   localparam logic [3:0] OP_MULTU = 4'b0110;
   localparam logic [3:0] OP_DIV   = 4'b1011;
   localparam logic [3:0] OP_DIVU  = 4'b0111;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
   function automatic logic op_legal(input logic [3:0] op);
      return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
   endfunction
endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EX-side op handshake, unit drive/return and HI/LO access bundle.
// div0 exists only when MDU_DIV0_EN is defined.
interface mdu_ctrl_if #(parameter int WIDTH = 32) ();
   logic             op_valid;
   logic [3:0]       op_code;
   logic [WIDTH-1:0] op_a, op_b;
   logic             flush;
   logic             stall, busy;
   logic [WIDTH-1:0] mdu_a, mdu_b;
   logic [3:0]       mdu_m;
   logic [WIDTH-1:0] mdu_hi, mdu_lo;
   logic             mt_hi, mt_lo;
   logic [WIDTH-1:0] mt_data;
   logic             mf_valid, mf_sel;
   logic [WIDTH-1:0] mf_data, hi, lo;
`ifdef MDU_DIV0_EN
   logic             div0;
`endif
   modport master (
      output op_valid, op_code, op_a, op_b, flush, mdu_hi, mdu_lo,
      output mt_hi, mt_lo, mt_data, mf_valid, mf_sel,
      input  stall, busy, mdu_a, mdu_b, mdu_m, mf_data, hi, lo
`ifdef MDU_DIV0_EN
      , input div0
`endif
   );
   modport slave (
      input  op_valid, op_code, op_a, op_b, flush, mdu_hi, mdu_lo,
      input  mt_hi, mt_lo, mt_data, mf_valid, mf_sel,
      output stall, busy, mdu_a, mdu_b, mdu_m, mf_data, hi, lo
`ifdef MDU_DIV0_EN
      , output div0
`endif
   );
endinterface

// File: rtl/mdu_ctrl_hilo_reg.sv
// hilo_reg: architectural HI/LO with unit-commit and MTHI/MTLO write ports and a read mux.
module hilo_reg #(parameter int WIDTH = 32) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             commit_i,
   input  logic [WIDTH-1:0] commit_hi_i,
   input  logic [WIDTH-1:0] commit_lo_i,
   input  logic             mt_hi_i,
   input  logic             mt_lo_i,
   input  logic [WIDTH-1:0] mt_data_i,
   input  logic             mf_sel_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] mf_data_o
);
   logic [WIDTH-1:0] hi_q, lo_q;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (commit_i) begin
         hi_q <= commit_hi_i;
         lo_q <= commit_lo_i;
      end else begin
         if (mt_hi_i) hi_q <= mt_data_i;
         if (mt_lo_i) lo_q <= mt_data_i;
      end
   end
   assign hi_o      = hi_q;
   assign lo_o      = lo_q;
   assign mf_data_o = mf_sel_i ? hi_q : lo_q;
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequences MULT/MULTU/DIV/DIVU through the LAT-deep mul/div unit and commits HI/LO.
// MDU_DIV0_EN: zero-divisor DIV/DIVU skips the unit and pulses div0 instead of committing.
module mdu_ctrl import mdu_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int LAT   = LAT_DEF
) (
   input logic       clk,
   input logic       resetn,
   mdu_ctrl_if.slave bus
);
   localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
   localparam logic [CW-1:0] LAST = CW'(LAT - 1);
   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [3:0]       m_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             d0_q;
   logic             accept, zdiv, idle_wr;
   assign accept = state_q == IDLE && bus.op_valid && !bus.flush && op_legal(bus.op_code);
`ifdef MDU_DIV0_EN
   assign zdiv = (bus.op_code == OP_DIV || bus.op_code == OP_DIVU) && bus.op_b == '0;
   assign bus.div0 = state_q == DONE && d0_q;
`else
   assign zdiv = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         m_q     <= OP_NONE;
         a_q     <= '0;
         b_q     <= '0;
         d0_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               state_q <= zdiv ? DONE : BUSY;
               cnt_q   <= '0;
               m_q     <= zdiv ? OP_NONE : bus.op_code;
               a_q     <= bus.op_a;
               b_q     <= bus.op_b;
               d0_q    <= zdiv;
            end
            BUSY: if (bus.flush) begin
               state_q <= IDLE;
               m_q     <= OP_NONE;
            end else if (cnt_q == LAST) state_q <= DONE;
            else cnt_q <= cnt_q + 1'b1;
            default: begin
               state_q <= IDLE;
               m_q     <= OP_NONE;
               d0_q    <= 1'b0;
            end
         endcase
      end
   end
   // m_q is cleared on every return to IDLE, so the unit sees OP_NONE whenever nothing is in flight
   assign bus.mdu_m = m_q;
   assign bus.mdu_a = a_q;
   assign bus.mdu_b = b_q;
   assign bus.busy  = state_q != IDLE;
   assign bus.stall = state_q == IDLE ? accept : state_q == BUSY;
   assign idle_wr   = state_q == IDLE && !bus.flush;
   hilo_reg #(.WIDTH(WIDTH)) u_hilo (
      .clk        (clk),
      .resetn     (resetn),
      .commit_i   (state_q == DONE && !bus.flush && !d0_q),
      .commit_hi_i(bus.mdu_hi),
      .commit_lo_i(bus.mdu_lo),
      .mt_hi_i    (idle_wr && bus.mt_hi),
      .mt_lo_i    (idle_wr && bus.mt_lo),
      .mt_data_i  (bus.mt_data),
      .mf_sel_i   (bus.mf_sel),
      .hi_o       (bus.hi),
      .lo_o       (bus.lo),
      .mf_data_o  (bus.mf_data)
   );
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: occupancy-window model of the sequencer plus a fake mul/div unit, checked every cycle.
module tb_mdu_ctrl;
   import mdu_pkg::*;
   localparam int W = 32;
   localparam int L = 5;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;
   mdu_ctrl_if #(.WIDTH(W)) bus ();
   mdu_ctrl #(.WIDTH(W), .LAT(L)) dut (.clk(clk), .resetn(resetn), .bus(bus));
   int n_chk = 0, n_pass = 0;
   logic chk_en = 1'b0;
   logic occ = 1'b0, m_d0 = 1'b0;
   int cyc = 0, t_acc = 0;
   logic [3:0] m_op = 4'b0;
   logic [W-1:0] e_hi = '0, e_lo = '0, e_a = '0, e_b = '0;
   logic done_now, acc_now;
   function automatic logic legal(input logic [3:0] op);
      return op == 4'b0101 || op == 4'b0110 || op == 4'b1011 || op == 4'b0111;
   endfunction
   function automatic logic is_d0(input logic [3:0] op, input logic [W-1:0] b);
`ifdef MDU_DIV0_EN
      return (op == 4'b1011 || op == 4'b0111) && b == 0;
`else
      return 1'b0;
`endif
   endfunction
   // reference result {hi, lo}; the unit returns {a, all-ones} for a zero divisor
   function automatic logic [63:0] res(input logic [3:0] op, input logic [W-1:0] a, b);
      longint sa = longint'($signed(a)), sb = longint'($signed(b));
      longint ua = longint'({32'b0, a}), ub = longint'({32'b0, b});
      if (op == 4'b0101) return 64'(sa * sb);
      if (op == 4'b0110) return 64'(ua * ub);
      if (b == 0) return {a, {W{1'b1}}};
      if (op == 4'b1011) return {32'(sa % sb), 32'(sa / sb)};
      return {32'(ua % ub), 32'(ua / ub)};
   endfunction
   assign done_now = occ && (cyc - t_acc == (m_d0 ? 1 : L + 1));
   assign acc_now  = !occ && bus.op_valid && !bus.flush && legal(bus.op_code);
   assign {bus.mdu_hi, bus.mdu_lo} = done_now ? res(m_op, e_a, e_b) : 64'hDEADBEEF_BAD0F00D;
   always @(posedge clk) begin
      if (!resetn) begin
         occ <= 1'b0; e_hi <= '0; e_lo <= '0; e_a <= '0; e_b <= '0;
      end else if (occ) begin
         if (bus.flush || done_now) occ <= 1'b0;
         if (done_now && !bus.flush && !m_d0) {e_hi, e_lo} <= res(m_op, e_a, e_b);
      end else if (!bus.flush) begin
         if (bus.mt_hi) e_hi <= bus.mt_data;
         if (bus.mt_lo) e_lo <= bus.mt_data;
         if (acc_now) begin
            occ <= 1'b1; t_acc <= cyc; m_op <= bus.op_code;
            e_a <= bus.op_a; e_b <= bus.op_b; m_d0 <= is_d0(bus.op_code, bus.op_b);
         end
      end
      cyc <= cyc + 1;
   end
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
   endtask
   always @(negedge clk) if (chk_en) begin
      check("stall", W'(bus.stall), W'(occ ? !done_now : acc_now));
      check("busy", W'(bus.busy), W'(occ));
      check("mdu_m", W'(bus.mdu_m), W'((occ && !m_d0) ? m_op : 4'b0));
      check("mdu_a", bus.mdu_a, e_a);
      check("mdu_b", bus.mdu_b, e_b);
      check("hi", bus.hi, e_hi);
      check("lo", bus.lo, e_lo);
      check("mf_data", bus.mf_data, bus.mf_sel ? e_hi : e_lo);
`ifdef MDU_DIV0_EN
      check("div0", W'(bus.div0), W'(done_now && m_d0));
`endif
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // hold the op in EX until stall drops (the DONE cycle), then retire it
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int ns);
      bus.op_valid = 1'b1; bus.op_code = op; bus.op_a = a; bus.op_b = b; ns = 0;
      #1;
      while (bus.stall === 1'b1 && ns < 20) begin
         ns++;
         step();
         #1;
      end
      step();
      bus.op_valid = 1'b0; bus.op_code = 4'b0;
   endtask
   initial begin
      int ns;
      bus.op_valid = 0; bus.op_code = 0; bus.op_a = 0; bus.op_b = 0; bus.flush = 0;
      bus.mt_hi = 0; bus.mt_lo = 0; bus.mt_data = 0; bus.mf_valid = 0; bus.mf_sel = 0;
      step(); step();
      resetn = 1'b1; chk_en = 1'b1;
      #1;
      check("rst_hi", bus.hi, 32'h0);
      check("rst_stall", W'(bus.stall), 32'h0);
      check("rst_mdu_m", W'(bus.mdu_m), 32'h0);
      step();
      run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, ns);
      #1;
      check("mult_stall_cycles", W'(ns), 32'd6);
      check("mult_busy_after", W'(bus.busy), 32'h0);
      check("mult_hi", bus.hi, 32'hFFFFFFFF);
      check("mult_lo", bus.lo, 32'hFFFFFFFA);
      bus.mf_valid = 1'b1; bus.mf_sel = 1'b1;
      #1;
      check("mfhi", bus.mf_data, 32'hFFFFFFFF);
      bus.mf_valid = 1'b0; bus.mf_sel = 1'b0;
      run_op(OP_DIVU, 32'd100, 32'd7, ns);
      #1;
      check("divu_stall_cycles", W'(ns), 32'd6);
      check("divu_lo", bus.lo, 32'd14);
      check("divu_hi", bus.hi, 32'd2);
      bus.mt_hi = 1'b1; bus.mt_data = 32'h12345678;
      step();
      bus.mt_hi = 1'b0;
      #1;
      check("mthi", bus.hi, 32'h12345678);
      bus.op_valid = 1'b1; bus.op_code = OP_MULTU; bus.op_a = 32'h10000; bus.op_b = 32'h10000;
      step(); step(); step();
      bus.flush = 1'b1; bus.op_valid = 1'b0;
      step();
      bus.flush = 1'b0;
      #1;
      check("flush_busy", W'(bus.busy), 32'h0);
      check("flush_hi", bus.hi, 32'h12345678);
      check("flush_lo", bus.lo, 32'd14);
      bus.op_valid = 1'b1; bus.op_code = OP_MULT; bus.op_a = 32'd7; bus.op_b = 32'd9;
      step(); step();
      resetn = 1'b0; bus.op_valid = 1'b0;
      step();
      resetn = 1'b1;
      #1;
      check("rstbusy_hi", bus.hi, 32'h0);
      check("rstbusy_lo", bus.lo, 32'h0);
      check("rstbusy_stall", W'(bus.stall), 32'h0);
      check("rstbusy_mdu_m", W'(bus.mdu_m), 32'h0);
      bus.mt_hi = 1'b1; bus.mt_lo = 1'b1; bus.mt_data = 32'hAAAA5555;
      step();
      bus.mt_hi = 1'b0; bus.mt_lo = 1'b0;
      #1;
      check("mt_both_hi", bus.hi, 32'hAAAA5555);
      check("mt_both_lo", bus.lo, 32'hAAAA5555);
      bus.op_valid = 1'b1; bus.op_code = 4'b0001;
      #1;
      check("illegal_stall", W'(bus.stall), 32'h0);
      step();
      bus.op_code = OP_MULT; bus.flush = 1'b1;
      #1;
      check("idle_flush_stall", W'(bus.stall), 32'h0);
      step();
      bus.op_valid = 1'b0; bus.flush = 1'b0;
      #1;
      check("idle_flush_busy", W'(bus.busy), 32'h0);
      run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, ns);
      #1;
      check("div_lo", bus.lo, 32'hFFFFFFFD);
      check("div_hi", bus.hi, 32'hFFFFFFFF);
      run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, ns);
      #1;
      check("multu_hi", bus.hi, 32'hFFFFFFFE);
      check("multu_lo", bus.lo, 32'h00000001);
`ifdef MDU_DIV0_EN
      bus.op_valid = 1'b1; bus.op_code = OP_DIV; bus.op_a = 32'd5; bus.op_b = 32'd0;
      #1;
      check("div0_accept_stall", W'(bus.stall), 32'h1);
      step();
      #1;
      check("div0_pulse", W'(bus.div0), 32'h1);
      check("div0_done_stall", W'(bus.stall), 32'h0);
      check("div0_mdu_m", W'(bus.mdu_m), 32'h0);
      step();
      bus.op_valid = 1'b0;
      #1;
      check("div0_after", W'(bus.div0), 32'h0);
      check("div0_hi", bus.hi, 32'hFFFFFFFE);
      check("div0_lo", bus.lo, 32'h00000001);
`else
      run_op(OP_DIVU, 32'd5, 32'd0, ns);
      #1;
      check("divz_stall_cycles", W'(ns), 32'd6);
      check("divz_hi", bus.hi, 32'd5);
      check("divz_lo", bus.lo, 32'hFFFFFFFF);
`endif
      step(); step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
